// File: rtl/exp_unit_arbiter.sv
// Round-robin arbiter sharing one LNS->linear antilog unit among N_REQ lanes.
// One operation in flight; a watchdog turns a stalled unit into an error
// response and drains any late result before granting again.

// Per-lane grant/response decode.
module exp_arb_lane #(
  parameter int ID_W = 2,
  parameter int LANE = 0
) (
  input  logic            grant_en,
  input  logic [ID_W-1:0] win_id,
  input  logic            rsp_en,
  input  logic [ID_W-1:0] grant_id,
  input  logic            rsp_rdy,
  output logic            req_rdy,
  output logic            rsp_vld,
  output logic            rsp_take
);
  localparam logic [ID_W-1:0] MY_ID = ID_W'(LANE);

  assign req_rdy  = grant_en && (win_id == MY_ID);
  assign rsp_vld  = rsp_en && (grant_id == MY_ID);
  // Only the owning lane's rsp_ready can complete the response.
  assign rsp_take = rsp_vld && rsp_rdy;
endmodule

module exp_unit_arbiter #(
  parameter int N_REQ          = 4,
  parameter int X_BITS         = 8,
  parameter int Y_BITS         = 8,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ID_W           = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*X_BITS-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [Y_BITS-1:0]       rsp_data,
  output logic                    rsp_err,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [X_BITS-1:0]       exp_data_in,
  output logic                    exp_data_in_valid,
  input  logic                    exp_data_in_enable,
  input  logic [Y_BITS-1:0]       exp_data_out,
  input  logic                    exp_data_out_valid,
  output logic                    exp_data_out_enable,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]              state;
  logic [ID_W-1:0]         last_grant;
  logic [CNT_W-1:0]        cnt;
  logic [X_BITS-1:0]       op;
  logic [Y_BITS-1:0]       res;
  logic                    err;
  logic                    stale;

  logic [N_REQ-1:0][X_BITS-1:0] lane_data;
  logic [ID_W-1:0]         win_id;
  logic                    win_found;
  logic                    grant_en;
  logic [N_REQ-1:0]        rsp_take;
  logic                    rsp_done;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    tmo_hit;

  assign lane_data = req_data;

  // Rotating priority search starting just after the last served lane.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!win_found && req_valid[ID_W'(idx)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // A late result from a timed-out op must drain before anyone is granted.
  assign grant_en = !rst && (state == S_IDLE) && !stale && win_found;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    exp_arb_lane #(.ID_W(ID_W), .LANE(i)) u_lane (
      .grant_en (grant_en),
      .win_id   (win_id),
      .rsp_en   (state == S_RESP),
      .grant_id (grant_id),
      .rsp_rdy  (rsp_ready[i]),
      .req_rdy  (req_ready[i]),
      .rsp_vld  (rsp_valid[i]),
      .rsp_take (rsp_take[i])
    );
  end

  assign rsp_done = |rsp_take;

  assign cnt_nxt = cnt + CNT_W'(1);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_nxt == CNT_W'(TIMEOUT_CYCLES));

  assign exp_data_in         = op;
  assign exp_data_in_valid   = (state == S_ISSUE);
  assign exp_data_out_enable = (state == S_WAIT) || stale;
  assign rsp_data            = (state == S_RESP) ? res : '0;
  assign rsp_err             = (state == S_RESP) && err;
  assign busy                = (state != S_IDLE);

  // Operation sequencer, watchdog and stale-result drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant_id   <= '0;
      last_grant <= ID_W'(N_REQ - 1);
      cnt        <= '0;
      op         <= '0;
      res        <= '0;
      err        <= 1'b0;
      stale      <= 1'b0;
    end else begin
      // Discard the abandoned result; stale is never set while it is set.
      if (stale && exp_data_out_valid) stale <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_en) begin
            op       <= lane_data[win_id];
            grant_id <= win_id;
            cnt      <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt <= cnt_nxt;
          if (exp_data_in_enable) begin
            state <= S_WAIT;
          end else if (tmo_hit) begin
            // Unit never took the operand, so nothing will come back.
            res   <= '0;
            err   <= 1'b1;
            state <= S_RESP;
          end
        end
        S_WAIT: begin
          cnt <= cnt_nxt;
          if (exp_data_out_valid) begin
            res   <= exp_data_out;
            err   <= 1'b0;
            state <= S_RESP;
          end else if (tmo_hit) begin
            res   <= '0;
            err   <= 1'b1;
            stale <= 1'b1;
            state <= S_RESP;
          end
        end
        default: begin
          if (rsp_done) begin
            last_grant <= grant_id;
            state      <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_exp_unit_arbiter.sv
// Directed bench for exp_unit_arbiter with a small behavioural antilog unit.
module tb_exp_unit_arbiter;
  localparam int N_REQ = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [3:0]  rsp_ready;
  logic [7:0]  exp_data_in;
  logic        exp_data_in_valid;
  logic        exp_data_in_enable;
  logic [7:0]  exp_data_out;
  logic        exp_data_out_valid;
  logic        exp_data_out_enable;
  logic        busy;
  logic [1:0]  grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  exp_unit_arbiter #(.N_REQ(N_REQ), .X_BITS(8), .Y_BITS(8), .TIMEOUT_CYCLES(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_data            (req_data),
    .req_ready           (req_ready),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .rsp_err             (rsp_err),
    .rsp_ready           (rsp_ready),
    .exp_data_in         (exp_data_in),
    .exp_data_in_valid   (exp_data_in_valid),
    .exp_data_in_enable  (exp_data_in_enable),
    .exp_data_out        (exp_data_out),
    .exp_data_out_valid  (exp_data_out_valid),
    .exp_data_out_enable (exp_data_out_enable),
    .busy                (busy),
    .grant_id            (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in unit: result = nibble swap of operand xor 8'hA5, after unit_lat cycles.
  int         unit_lat;
  logic       unit_hang;
  logic       u_busy;
  logic       u_vld;
  logic [7:0] u_op;
  int         u_cnt;

  assign exp_data_in_enable = !u_busy;
  assign exp_data_out_valid = u_vld;
  assign exp_data_out       = {u_op[3:0], u_op[7:4]} ^ 8'hA5;

  always @(posedge clk) begin
    if (rst) begin
      u_busy <= 1'b0;
      u_vld  <= 1'b0;
      u_op   <= 8'h00;
      u_cnt  <= 0;
    end else if (u_vld && exp_data_out_enable) begin
      u_vld  <= 1'b0;
      u_busy <= 1'b0;
    end else if (!u_busy && exp_data_in_valid && exp_data_in_enable) begin
      u_busy <= 1'b1;
      u_op   <= exp_data_in;
      u_cnt  <= unit_lat;
    end else if (u_busy && !u_vld) begin
      if (u_cnt != 0) u_cnt <= u_cnt - 1;
      else if (!unit_hang) u_vld <= 1'b1;
    end
  end

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          lat;
    int          lane;
    logic [7:0]  op;
    logic [7:0]  res;
  } row_t;

  row_t rows[8];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'h0;
    rsp_ready = 4'h0;
    unit_hang = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // One full transaction: grant, issue, result, response handshake.
  task automatic run_row(input row_t r);
    int n;
    req_valid = r.mask;
    req_data  = r.data;
    unit_lat  = r.lat;
    #1;
    n = 0;
    while (req_ready == 4'h0 && n < 20) begin tick(); n++; end
    chk("grant", 32'(req_ready), 32'(1 << r.lane));
    tick();
    chk("issue_op", {23'h0, exp_data_in_valid, exp_data_in}, {23'h0, 1'b1, r.op});
    chk("grant_id", 32'(grant_id), 32'(r.lane));
    n = 0;
    while (rsp_valid == 4'h0 && n < 40) begin tick(); n++; end
    chk("latency", 32'(n), 32'(r.lat + 3));
    chk("rsp_valid", 32'(rsp_valid), 32'(1 << r.lane));
    chk("rsp_data", 32'(rsp_data), 32'(r.res));
    chk("rsp_err", 32'(rsp_err), 32'h0);
    rsp_ready = 4'(1 << r.lane);
    tick();
    rsp_ready = 4'h0;
    chk("release", {30'h0, busy, |rsp_valid}, 32'h0);
  endtask

  initial begin
    int n;
    rows[0] = '{4'b1111, 32'h10204080, 0, 0, 8'h80, 8'hAD};
    rows[1] = '{4'b1111, 32'h10204080, 1, 1, 8'h40, 8'hA1};
    rows[2] = '{4'b1111, 32'h10204080, 2, 2, 8'h20, 8'hA7};
    rows[3] = '{4'b1111, 32'h10204080, 3, 3, 8'h10, 8'hA4};
    rows[4] = '{4'b1111, 32'h10204080, 0, 0, 8'h80, 8'hAD};
    rows[5] = '{4'b0100, 32'h00800000, 1, 2, 8'h80, 8'hAD};
    rows[6] = '{4'b1010, 32'h3C00C300, 2, 3, 8'h3C, 8'h66};
    rows[7] = '{4'b1010, 32'h3C00C300, 1, 1, 8'hC3, 8'h99};

    // Reset with every lane requesting.
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'h0;
    rsp_ready = 4'h0;
    unit_lat  = 0;
    unit_hang = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp", {29'h0, rsp_err, |rsp_valid, busy}, 32'h0);
    chk("rst_unit_if", {30'h0, exp_data_in_valid, exp_data_out_enable}, 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_first_prio", 32'(req_ready), 32'h1);

    // Round robin, single lane, and partial masks.
    for (int i = 0; i < 8; i++) run_row(rows[i]);

    // Backpressure: response held, other lanes' rsp_ready ignored.
    do_reset();
    unit_lat  = 1;
    req_valid = 4'b1000;
    req_data  = 32'h10000000;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h8);
    tick();
    n = 0;
    while (rsp_valid == 4'h0 && n < 40) begin tick(); n++; end
    chk("bp_data", 32'(rsp_data), 32'hA4);
    req_valid = 4'b1001;
    rsp_ready = 4'b0111;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_hold", {24'h0, rsp_valid, req_ready}, 32'h80);
      tick();
    end
    rsp_ready = 4'b1000;
    tick();
    rsp_ready = 4'h0;
    chk("bp_release", {27'h0, busy, req_ready}, 32'h1);
    req_valid = 4'h0;

    // Watchdog fires in WAIT; late result must drain before next grant.
    do_reset();
    unit_lat  = 0;
    unit_hang = 1'b1;
    req_valid = 4'b0010;
    req_data  = 32'h00003300;
    #1;
    chk("tmo_grant", 32'(req_ready), 32'h2);
    tick();
    n = 0;
    while (rsp_valid == 4'h0 && n < 30) begin tick(); n++; end
    chk("tmo_cycles", 32'(n), 32'd8);
    chk("tmo_rsp", {22'h0, rsp_valid, rsp_err, rsp_data}, {22'h0, 4'b0010, 1'b1, 8'h00});
    rsp_ready = 4'b0010;
    req_valid = 4'b0011;
    tick();
    rsp_ready = 4'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stale_block", {27'h0, busy, req_ready}, 32'h0);
      chk("stale_drain_en", 32'(exp_data_out_enable), 32'h1);
      tick();
    end
    unit_hang = 1'b0;
    n = 0;
    while (req_ready == 4'h0 && n < 10) begin tick(); n++; end
    chk("post_stale_grant", 32'(req_ready), 32'h1);
    chk("post_stale_en", 32'(exp_data_out_enable), 32'h0);
    req_valid = 4'h0;
    tick();
    chk("drop_before_accept", 32'(busy), 32'h0);

    // Reset while the unit is computing.
    do_reset();
    unit_hang = 1'b1;
    req_valid = 4'b0100;
    req_data  = 32'h00200000;
    #1;
    chk("mid_grant", 32'(req_ready), 32'h4);
    tick();
    tick();
    tick();
    chk("mid_in_wait", 32'(exp_data_out_enable), 32'h1);
    rst       = 1'b1;
    req_valid = 4'h0;
    tick();
    rst       = 1'b0;
    unit_hang = 1'b0;
    chk("mid_abort", {29'h0, busy, |rsp_valid, exp_data_out_enable}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_rsp", 32'(rsp_valid), 32'h0);
    end
    run_row('{4'b0001, 32'h00000080, 0, 0, 8'h80, 8'hAD});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end
endmodule
